// File: rtl/jt1942_snd_pkg.sv
// jt1942_snd_pkg: sound memory map, reset FSM states and IRQ vector
package jt1942_snd_pkg;
  localparam logic [15:0] ROM_LIM   = 16'h3FFF;
  localparam logic [15:0] RAM_BASE  = 16'h4000;
  localparam logic [15:0] RAM_LIM   = 16'h47FF;
  localparam logic [15:0] LAT0_ADDR = 16'h6000;
  localparam logic [15:0] LAT1_ADDR = 16'h6001;
  localparam logic [15:0] AY0_BASE  = 16'h8000;
  localparam logic [15:0] AY0_LIM   = 16'hBFFF;
  localparam logic [15:0] AY1_BASE  = 16'hC000;
  localparam logic [7:0]  IRQ_VEC   = 8'hFF;
  localparam logic [7:0]  OPEN_BUS  = 8'hFF;
  typedef enum logic [1:0] {HOLD, COUNT, RUN} rst_st_e;
endpackage

// File: rtl/jt1942_rst_stretch.sv
// jt1942_rst_stretch: holds the sound CPU in reset for RST_HOLD cen_snd ticks after sres_b rises
module jt1942_rst_stretch
  import jt1942_snd_pkg::*;
#(
  parameter int RST_HOLD = 16,
  localparam int CW = $clog2(RST_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sres_b,
  input  logic          cen_snd,
  output logic [CW-1:0] count,
  output logic          snd_rst_n
);
  rst_st_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rst_n_q, rst_n_d;
  logic done;
  assign done = cen_snd && cnt_q == CW'(RST_HOLD - 1);
  assign count = cnt_q;
  assign snd_rst_n = rst_n_q;
  // next state: sres_b low always returns to HOLD; counter only advances in COUNT so it saturates in RUN
  always_comb begin
    st_d = !sres_b ? HOLD : st_q == HOLD ? COUNT : (st_q == COUNT && done) ? RUN : st_q;
    cnt_d = (!sres_b || st_q == HOLD) ? '0 : (st_q == COUNT && cen_snd) ? cnt_q + 1'b1 : cnt_q;
    rst_n_d = st_d == RUN;
  end
  // state, counter and registered reset output
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= HOLD;
      cnt_q <= '0;
      rst_n_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      rst_n_q <= rst_n_d;
    end
  end
endmodule

// File: rtl/jt1942_sndif.sv
// jt1942_sndif: sound CPU glue - latches, address decode, read mux, IRQ and reset stretch
module jt1942_sndif
  import jt1942_snd_pkg::*;
#(
  parameter int RST_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen3,
  input  logic        cen_snd,
  input  logic [7:0]  main_dout,
  input  logic        snd_latch0_cs,
  input  logic        snd_latch1_cs,
  input  logic        sres_b,
  input  logic        snd_int,
  input  logic [15:0] snd_A,
  input  logic        snd_rd_n,
  input  logic        snd_wr_n,
  input  logic        snd_mreq_n,
  input  logic        snd_iorq_n,
  input  logic        snd_m1_n,
  input  logic [7:0]  rom_data,
  input  logic [7:0]  ram_dout,
  input  logic [7:0]  ay_dout,
  output logic [7:0]  snd_din,
  output logic        rom_cs,
  output logic        ram_cs,
  output logic        ay0_cs,
  output logic        ay1_cs,
  output logic        ay_a0,
  output logic        snd_rst_n,
  output logic        snd_int_n
);
  localparam int CW = $clog2(RST_HOLD + 1);
  logic [7:0] latch0_q, latch0_d, latch1_q, latch1_d;
  logic int_last_q, int_last_d, pend_q, pend_d;
  logic ack, int_edge, mreq, lat0_rd, lat1_rd;
  logic [CW-1:0] rst_cnt;
  logic unused_ok;
  jt1942_rst_stretch #(.RST_HOLD(RST_HOLD)) u_stretch (
    .clk(clk), .rst(rst), .sres_b(sres_b), .cen_snd(cen_snd),
    .count(rst_cnt), .snd_rst_n(snd_rst_n)
  );
  assign unused_ok = &{1'b0, snd_wr_n, rst_cnt};
  assign mreq = !snd_mreq_n;
  assign ack = !snd_iorq_n && !snd_m1_n;
  assign int_edge = cen3 && snd_int && !int_last_q;
  assign rom_cs = mreq && snd_A <= ROM_LIM;
  assign ram_cs = mreq && snd_A >= RAM_BASE && snd_A <= RAM_LIM;
  assign ay0_cs = mreq && snd_A >= AY0_BASE && snd_A <= AY0_LIM;
  assign ay1_cs = mreq && snd_A >= AY1_BASE;
  assign ay_a0 = snd_A[0];
  assign lat0_rd = mreq && !snd_rd_n && snd_A == LAT0_ADDR;
  assign lat1_rd = mreq && !snd_rd_n && snd_A == LAT1_ADDR;
  assign snd_int_n = ~pend_q;
  // read mux: ack vector beats every memory source
  assign snd_din = ack ? IRQ_VEC : rom_cs ? rom_data : ram_cs ? ram_dout : lat0_rd ? latch0_q :
                   lat1_rd ? latch1_q : (ay0_cs || ay1_cs) ? ay_dout : OPEN_BUS;
  // latch loads, edge history on cen3, and pending flag where a fresh edge outranks the ack
  always_comb begin
    latch0_d = (cen3 && snd_latch0_cs) ? main_dout : latch0_q;
    latch1_d = (cen3 && snd_latch1_cs) ? main_dout : latch1_q;
    int_last_d = cen3 ? snd_int : int_last_q;
    pend_d = !snd_rst_n ? 1'b0 : int_edge ? 1'b1 : (cen_snd && ack) ? 1'b0 : pend_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      latch0_q <= '0;
      latch1_q <= '0;
      int_last_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      latch0_q <= latch0_d;
      latch1_q <= latch1_d;
      int_last_q <= int_last_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: doc/jt1942_sndif.md
JT1942_SNDIF -- requirements
Module: jt1942_sndif

Interface
REQ-001 Parameter RST_HOLD, default 16, number of cen_snd ticks the sound CPU reset is held after release.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cen3  in  1  main-CPU clock enable, 3 MHz.
REQ-005 cen_snd  in  1  sound-CPU clock enable, 1.5 MHz.
REQ-006 main_dout  in  8  main-CPU write data.
REQ-007 snd_latch0_cs, snd_latch1_cs  in  1 each  main-CPU latch write strobes.
REQ-008 sres_b  in  1  sound reset request, active-low.
REQ-009 snd_int  in  1  interrupt timing line from the vertical PROM.
REQ-010 snd_A  in  16  sound-CPU address.
REQ-011 snd_rd_n, snd_wr_n, snd_mreq_n, snd_iorq_n, snd_m1_n  in  1 each  sound-CPU bus strobes.
REQ-012 rom_data, ram_dout, ay_dout  in  8 each  read data from sound ROM, sound RAM and the selected AY.
REQ-013 snd_din  out  8  sound-CPU read data.
REQ-014 rom_cs, ram_cs, ay0_cs, ay1_cs  out  1 each  device selects.
REQ-015 ay_a0  out  1  AY address/data select, equal to snd_A[0].
REQ-016 snd_rst_n  out  1  sound-CPU reset, active-low.
REQ-017 snd_int_n  out  1  sound-CPU interrupt, active-low.

Function
REQ-018 Latch n SHALL load main_dout on a clk edge with cen3 high and snd_latchn_cs high; otherwise it holds its value.
REQ-019 A load and a sound read of the same latch in the same cycle SHALL return the old value; the new value is readable from the next clk.
REQ-020 Decode SHALL be qualified by snd_mreq_n low: 0000-3FFF rom_cs, 4000-47FF ram_cs, 8000-BFFF ay0_cs, C000-FFFF ay1_cs.
REQ-021 Reads SHALL be mapped as follows: 6000 returns latch0, 6001 returns latch1.
REQ-022 Reads of unmapped addresses (4800-5FFF, 6002-7FFF) SHALL return FF.
REQ-023 snd_din SHALL be combinational with priority: irq ack (snd_iorq_n and snd_m1_n both low) gives FF (RST 38h), then ROM, RAM, latch, AY (ay_dout), otherwise FF.
REQ-024 snd_int SHALL be sampled on cen3; a 0->1 transition SHALL set the irq pending flag; snd_int_n = ~pending.
REQ-025 Pending SHALL clear on a clk with cen_snd high and irq ack active.
REQ-026 If a new rising edge and an ack coincide, pending SHALL remain set.
REQ-027 A level-high snd_int without an edge SHALL NOT re-set pending.
REQ-028 Reset FSM states are HOLD, COUNT, RUN; snd_rst_n is low in HOLD and COUNT, high in RUN.
REQ-029 HOLD->COUNT when sres_b is high; the counter loads 0.
REQ-030 COUNT increments on cen_snd and goes to RUN when the counter reaches RST_HOLD-1 on a cen_snd tick.
REQ-031 Any state SHALL go to HOLD when sres_b is low.
REQ-032 Counter width SHALL be $clog2(RST_HOLD+1) and SHALL not wrap (saturates in RUN).
REQ-033 While snd_rst_n is low, pending SHALL be forced clear and the edge detector keeps tracking snd_int; latches SHALL keep their values.

Reset
REQ-034 On rst: latch0 = latch1 = 00, pending = 0, snd_int_n = 1, edge-history register = 0, FSM = HOLD, counter = 0, snd_rst_n = 0.
REQ-035 All state SHALL update only on clk rising edges; no asynchronous paths.

Structure
REQ-036 The sound memory map base/limit constants and the FSM state encoding SHALL live in a shared package, jt1942_snd_pkg, alongside the IRQ vector constant FF.
REQ-037 The reset stretcher SHALL be a sub-module, jt1942_rst_stretch (sres_b, cen_snd, count -> snd_rst_n).

Verification
REQ-038 Reset test: assert rst, release it with sres_b=1 -> snd_rst_n low for exactly 16 cen_snd ticks, then high; latch reads of 6000 return 00.
REQ-039 Latch test: with cen3, write 5A to latch0 and A5 to latch1 -> sound reads at 6000 give 5A and at 6001 give A5; a same-cycle write of 33 and read of 6000 returns 5A, then 33.
REQ-040 IRQ test: snd_int 0->1 -> snd_int_n low within one cen3; ack cycle -> snd_din = FF and snd_int_n high after that cen_snd edge; snd_int held high -> no reassertion.
REQ-041 Coincidence test: a snd_int edge in the same clk as the ack cen_snd -> snd_int_n stays low.
REQ-042 Mid-count reset test: sres_b low at count 7 -> HOLD; sres_b high again -> a full 16 ticks before snd_rst_n rises; pending is cleared throughout.
REQ-043 Decode sweep: reads at 0000, 4000, 47FF, 5000, 8001, C000 with mreq_n low -> rom/ram/ram/none(FF)/ay0 (ay_a0=1)/ay1 selected; with mreq_n high -> no cs.
